irig_frame_sequencer: RTL and testbench
=======================================

// Module: irig_frame_sequencer
// PURPOSE
//  Front-end sequencer for the IRIG-B symbol decoder. Samples the raw IRIG-B line, measures each
//  pulse's high time and classifies it as a zero, one or marker. Acquires frame sync (P0 then Pr)
//  and drives the decoder's cal/en/irig_data/ind inputs, one strobe per symbol, with a frame index 0..99.
// PARAMETERS
//  CLK_PER_MS  10   clk cycles (with ce=1) per millisecond of IRIG time; sets every threshold below
//  ERR_W       8    width of the saturating error counter
// PORTS
//  clk         in   1      system clock
//  hrd_rst_n   in   1      reset, synchronous, active-low
//  ce          in   1      clock enable; counters/FSM advance only when ce=1
//  irig_in     in   1      raw IRIG-B DC-level input, asynchronous
//  irig_data   out  3      symbol code: 001 zero, 011 one, 111 marker, 000 none
//  en          out  1      1-clk strobe: irig_data/ind valid for the new symbol
//  ind         out  8      frame position 0..99 of the current symbol
//  cal         out  1      1-clk pulse when sync is acquired (with en of the Pr symbol)
//  locked      out  1      high while frame sync is held
//  frame_done  out  1      1-clk pulse with the en of ind=99
//  sync_lost   out  1      1-clk pulse when lock drops
//  err_cnt     out  ERR_W  saturating count of classification/position errors
//  state       out  2      FSM state, for debug
// BEHAVIOUR
//  Clock and reset:
//  - One clock (clk). Reset is synchronous, active-low on hrd_rst_n.
//  - Reset (hrd_rst_n=0 at a clk edge): all outputs 0, state=HUNT, counters 0, sync flops 0.
//  - Reset mid-frame: same values on the next edge; lock must be re-acquired.
//  Input sampling:
//  - irig_in goes through a 2-flop synchronizer plus 1 edge-detect register; these run every clk.
//  Measurement (ce-qualified):
//  - hi_cnt clears on a rising edge and increments while high; it saturates at 2^16-1.
//  - per_cnt clears on a rising edge and increments every ce cycle.
//  Classification (at the synchronized falling edge), with w = hi_cnt:
//  - w < CLK_PER_MS:                             ERR
//  - CLK_PER_MS <= w < 7*CLK_PER_MS/2:           ZERO
//  - 7*CLK_PER_MS/2 <= w < 13*CLK_PER_MS/2:      ONE
//  - 13*CLK_PER_MS/2 <= w < 19*CLK_PER_MS/2:     MARKER
//  - w >= 19*CLK_PER_MS/2:                       ERR (flagged immediately; does not wait for the fall)
//  - per_cnt >= 12*CLK_PER_MS with no rising edge: ERR (line dead).
//  - Latency: en asserts on the clk edge after the falling edge is detected (4 clk after irig_in
//    falls, ce=1). irig_data and ind are updated on that same edge and held until the next en.
//  FSM states:
//  - HUNT: wait for a MARKER; on MARKER -> ARM. No en is issued in HUNT.
//  - ARM: previous symbol was a marker (candidate P0).
//    - MARKER -> LOCK with ind=0; en=1, cal=1, irig_data=111, locked=1.
//    - ZERO or ONE -> HUNT.
//  - LOCK: each valid symbol sets ind <= (ind==99) ? 0 : ind+1 and pulses en.
//    - frame_done pulses when the new ind==99.
//    - Required markers: ind in {0,9,19,...,99}. A MARKER elsewhere, or a non-marker at a required
//      position, is a position error.
//  - ERR or position error in LOCK: en=0, locked<=0, sync_lost=1, err_cnt+1, -> HUNT, ind<=0.
//  - ERR in HUNT/ARM: err_cnt+1 and -> HUNT; no sync_lost.
//  Boundaries and simultaneous events:
//  - err_cnt saturates at all-ones.
//  - ce=0 freezes the counters and FSM; pulses are never stretched (a pulse lasts exactly one clk).
//  - Rising edge and timeout in the same cycle: the edge wins.
//  - hrd_rst_n low overrides everything else.
// STRUCTURE
//  Package irig_pkg:
//  - symbol codes SYM_ZERO=3'b001, SYM_ONE=3'b011, SYM_MARK=3'b111, SYM_NONE=3'b000
//  - FRAME_LEN=100; marker-position function is_marker_pos(ind)
//  - FSM encoding HUNT=0, ARM=1, LOCK=2
//  Sub-module irig_pulse_meter:
//  - synchronizer, edge detect, hi_cnt/per_cnt and classifier
//  - outputs sym_valid and sym_code
//  Top level: the FSM, ind counter and err_cnt.
// TESTING (CLK_PER_MS=10, ce=1; zero=20, one=50, marker=80 high cycles, 100-cycle period)
//  1 Reset:
//    - hold hrd_rst_n=0 for 3 clk with irig_in toggling
//    - all outputs 0, state=HUNT.
//  2 Acquire:
//    - send M,M,0
//    - second M: en=1, cal=1, ind=0, irig_data=111
//    - the 0: en=1, ind=1, irig_data=001, cal=0.
//  3 Full frame:
//    - send 100 symbols with markers at 0,9,...,99 and ones elsewhere
//    - 100 en pulses; frame_done at ind=99; next symbol ind=0 with locked still 1.
//  4 Misplaced marker:
//    - while locked, send M at ind=5
//    - no en; sync_lost=1, locked=0, err_cnt=1, ind=0
//    - relock only after M,M.
//  5 Timeout and glitch:
//    - high for 96 cycles -> ERR before the fall
//    - 5-cycle pulse -> ERR
//    - each increments err_cnt, with no en.
//  6 ce and reset:
//    - ce=0 for 50 cycles mid-pulse -> the classification is unchanged
//    - hrd_rst_n=0 at ind=42 -> ind=0, locked=0 on the next edge.

Source files
------------

// File: rtl/irig_pkg.sv
// Shared IRIG-B definitions: symbol codes, frame geometry, FSM encoding and
// the pulse classifier result type.
package irig_pkg;

  localparam logic [2:0] SYM_ZERO = 3'b001;
  localparam logic [2:0] SYM_ONE  = 3'b011;
  localparam logic [2:0] SYM_MARK = 3'b111;
  localparam logic [2:0] SYM_NONE = 3'b000;

  localparam int unsigned FRAME_LEN = 100;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    ARM  = 2'd1,
    LOCK = 2'd2
  } fsm_t;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_ONE  = 2'd1,
    CLS_MARK = 2'd2,
    CLS_ERR  = 2'd3
  } sym_cls_t;

  // Position identifiers P0..P9 plus the frame reference Pr at index 0.
  function automatic logic is_marker_pos(input logic [7:0] ind);
    return (ind == 8'd0) || ((ind % 8'd10) == 8'd9);
  endfunction

endpackage

// File: rtl/irig_pulse_meter.sv
// Synchronises the raw IRIG-B line, measures high time / period and emits one
// classified symbol strobe per pulse (or an error strobe for bad/dead lines).
module irig_pulse_meter
  import irig_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 10
) (
  input  logic     clk,
  input  logic     hrd_rst_n,
  input  logic     i_ce,
  input  logic     i_irig,
  output logic     o_sym_valid,
  output sym_cls_t o_sym_code
);

  localparam int unsigned TH_ZERO = CLK_PER_MS;
  localparam int unsigned TH_ONE  = 7 * CLK_PER_MS / 2;
  localparam int unsigned TH_MARK = 13 * CLK_PER_MS / 2;
  localparam int unsigned TH_MAX  = 19 * CLK_PER_MS / 2;
  localparam int unsigned TH_DEAD = 12 * CLK_PER_MS;

  logic        r_sync1, r_sync2, r_prev;
  logic [15:0] r_hi_cnt, r_per_cnt;
  logic        r_hi_flag, r_dead_flag;
  logic        w_rise, w_fall, w_too_long, w_dead;
  sym_cls_t    w_cls;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_fall = ~r_sync2 & r_prev;
  // Over-long and dead-line errors fire once per pulse; a rising edge always wins.
  assign w_too_long = r_sync2 && !w_rise && !r_hi_flag && (r_hi_cnt >= 16'(TH_MAX));
  assign w_dead     = !w_rise && !r_dead_flag && (r_per_cnt >= 16'(TH_DEAD));

  always_comb begin
    w_cls = CLS_ERR;
    if (r_hi_cnt < 16'(TH_ZERO))      w_cls = CLS_ERR;
    else if (r_hi_cnt < 16'(TH_ONE))  w_cls = CLS_ZERO;
    else if (r_hi_cnt < 16'(TH_MARK)) w_cls = CLS_ONE;
    else if (r_hi_cnt < 16'(TH_MAX))  w_cls = CLS_MARK;
  end

  always_ff @(posedge clk) begin
    if (!hrd_rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_prev      <= 1'b0;
      r_hi_cnt    <= '0;
      r_per_cnt   <= '0;
      r_hi_flag   <= 1'b0;
      r_dead_flag <= 1'b0;
      o_sym_valid <= 1'b0;
      o_sym_code  <= CLS_ZERO;
    end else begin
      r_sync1     <= i_irig;
      r_sync2     <= r_sync1;
      r_prev      <= r_sync2;
      o_sym_valid <= 1'b0;
      if (i_ce) begin
        if (w_rise) begin
          r_hi_cnt    <= '0;
          r_per_cnt   <= '0;
          r_hi_flag   <= 1'b0;
          r_dead_flag <= 1'b0;
        end else begin
          if (r_sync2 && (r_hi_cnt != '1)) r_hi_cnt <= r_hi_cnt + 16'd1;
          if (r_per_cnt != '1)             r_per_cnt <= r_per_cnt + 16'd1;
          if (w_too_long)                  r_hi_flag <= 1'b1;
          if (w_dead)                      r_dead_flag <= 1'b1;
        end
        if (w_too_long || w_dead) begin
          o_sym_valid <= 1'b1;
          o_sym_code  <= CLS_ERR;
        end else if (w_fall && !r_hi_flag) begin
          o_sym_valid <= 1'b1;
          o_sym_code  <= w_cls;
        end
      end
    end
  end

endmodule

// File: rtl/irig_frame_sequencer.sv
// IRIG-B front-end sequencer: acquires P0/Pr frame sync from classified
// symbols and feeds the decoder with one strobe, code and index per symbol.
module irig_frame_sequencer
  import irig_pkg::*;
#(
  parameter int unsigned CLK_PER_MS = 10,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             hrd_rst_n,
  input  logic             ce,
  input  logic             irig_in,
  output logic [2:0]       irig_data,
  output logic             en,
  output logic [7:0]       ind,
  output logic             cal,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_lost,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state
);

  logic       w_sym_valid;
  sym_cls_t   w_sym_code;
  fsm_t       r_state;
  logic [7:0] w_next_ind;
  logic       w_pos_ok;
  logic [2:0] w_sym_bits;

  irig_pulse_meter #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_meter (
    .clk        (clk),
    .hrd_rst_n  (hrd_rst_n),
    .i_ce       (ce),
    .i_irig     (irig_in),
    .o_sym_valid(w_sym_valid),
    .o_sym_code (w_sym_code)
  );

  assign state      = r_state;
  assign w_next_ind = (ind == 8'(FRAME_LEN - 1)) ? '0 : ind + 8'd1;
  // A marker must land exactly on a marker slot, and a data bit never may.
  assign w_pos_ok   = ((w_sym_code == CLS_MARK) == is_marker_pos(w_next_ind));

  always_comb begin
    w_sym_bits = SYM_NONE;
    case (w_sym_code)
      CLS_ZERO: w_sym_bits = SYM_ZERO;
      CLS_ONE:  w_sym_bits = SYM_ONE;
      CLS_MARK: w_sym_bits = SYM_MARK;
      default:  w_sym_bits = SYM_NONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!hrd_rst_n) begin
      r_state    <= HUNT;
      irig_data  <= SYM_NONE;
      en         <= 1'b0;
      ind        <= '0;
      cal        <= 1'b0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      sync_lost  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      en         <= 1'b0;
      cal        <= 1'b0;
      frame_done <= 1'b0;
      sync_lost  <= 1'b0;
      if (ce && w_sym_valid) begin
        if ((w_sym_code == CLS_ERR) || ((r_state == LOCK) && !w_pos_ok)) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          if (r_state == LOCK) begin
            sync_lost <= 1'b1;
            locked    <= 1'b0;
            ind       <= '0;
          end
          r_state <= HUNT;
        end else begin
          case (r_state)
            HUNT: if (w_sym_code == CLS_MARK) r_state <= ARM;
            ARM: begin
              if (w_sym_code == CLS_MARK) begin
                r_state   <= LOCK;
                ind       <= '0;
                en        <= 1'b1;
                cal       <= 1'b1;
                irig_data <= SYM_MARK;
                locked    <= 1'b1;
              end else begin
                r_state <= HUNT;
              end
            end
            LOCK: begin
              ind        <= w_next_ind;
              en         <= 1'b1;
              irig_data  <= w_sym_bits;
              frame_done <= (w_next_ind == 8'(FRAME_LEN - 1));
            end
            default: r_state <= HUNT;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// Bench for irig_frame_sequencer: pulse-train stimulus with a symbol-level
// frame model predicting every output on every cycle.
module tb_irig_frame_sequencer;

  localparam int unsigned CPM     = 10;
  localparam int unsigned EW      = 4;
  localparam int unsigned TH_MAX  = 19 * CPM / 2;
  localparam int unsigned TH_DEAD = 12 * CPM;
  localparam int K_ZERO = 0, K_ONE = 1, K_MARK = 2, K_ERR = 3;

  logic          clk = 1'b0, hrd_rst_n = 1'b0, ce = 1'b1, irig_in = 1'b0;
  logic [2:0]    irig_data;
  logic          en, cal, locked, frame_done, sync_lost;
  logic [7:0]    ind;
  logic [EW-1:0] err_cnt;
  logic [1:0]    state;

  irig_frame_sequencer #(.CLK_PER_MS(CPM), .ERR_W(EW)) dut (
    .clk(clk), .hrd_rst_n(hrd_rst_n), .ce(ce), .irig_in(irig_in),
    .irig_data(irig_data), .en(en), .ind(ind), .cal(cal), .locked(locked),
    .frame_done(frame_done), .sync_lost(sync_lost), .err_cnt(err_cnt), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int unsigned cyc = 0;
  logic rst_seen = 1'b1;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !hrd_rst_n;
  end

  // Expected symbol outcomes, keyed by the clock edge count at which they must show.
  typedef struct { int unsigned due; int kind; } ev_t;
  ev_t evq[$];

  int   m_state, m_ind, m_err;
  logic [2:0] m_data;
  bit   m_locked, m_en, m_cal, m_fd, m_sl;
  int   n_en = 0, n_cal = 0, n_fd = 0, n_sl = 0;
  int unsigned last_rise = 0;

  function automatic int classify(int w);
    if (w < int'(CPM))        return K_ERR;
    if (w < int'(7*CPM/2))    return K_ZERO;
    if (w < int'(13*CPM/2))   return K_ONE;
    if (w < int'(19*CPM/2))   return K_MARK;
    return K_ERR;
  endfunction

  function automatic bit marker_slot(int p);
    return (p == 0) || (p % 10 == 9);
  endfunction

  task automatic model_reset();
    m_state = 0; m_ind = 0; m_err = 0; m_data = 3'b000; m_locked = 0;
  endtask

  task automatic model_apply(int k);
    bit bad;
    bad = (k == K_ERR) || (m_state == 2 && ((k == K_MARK) != marker_slot((m_ind + 1) % 100)));
    if (bad) begin
      if (m_err < (1 << EW) - 1) m_err = m_err + 1;
      if (m_state == 2) begin m_sl = 1; m_locked = 0; m_ind = 0; end
      m_state = 0;
    end else if (m_state == 0) begin
      if (k == K_MARK) m_state = 1;
    end else if (m_state == 1) begin
      if (k == K_MARK) begin
        m_state = 2; m_ind = 0; m_en = 1; m_cal = 1; m_data = 3'b111; m_locked = 1;
      end else m_state = 0;
    end else begin
      m_ind  = (m_ind + 1) % 100;
      m_en   = 1;
      m_data = (k == K_ZERO) ? 3'b001 : (k == K_ONE) ? 3'b011 : 3'b111;
      m_fd   = (m_ind == 99);
    end
  endtask

  initial begin : compare
    @(negedge clk);
    forever begin
      m_en = 0; m_cal = 0; m_fd = 0; m_sl = 0;
      if (rst_seen) begin
        model_reset();
        evq.delete();
      end else if (evq.size() > 0) begin
        if (evq[0].due == cyc) begin
          model_apply(evq[0].kind);
          void'(evq.pop_front());
        end else if (evq[0].due < cyc) begin
          errors++;
          $display("FAIL event_order: pending event due %0d at cycle %0d", evq[0].due, cyc);
          void'(evq.pop_front());
        end
      end
      checks++;
      if ({state, err_cnt, locked, ind, irig_data, en, cal, frame_done, sync_lost} !==
          {2'(m_state), EW'(m_err), m_locked, 8'(m_ind), m_data, m_en, m_cal, m_fd, m_sl}) begin
        errors++;
        $display("FAIL cycle_%0d outputs: got st=%0d err=%0d lk=%b ind=%0d d=%b en=%b cal=%b fd=%b sl=%b, required st=%0d err=%0d lk=%b ind=%0d d=%b en=%b cal=%b fd=%b sl=%b",
                 cyc, state, err_cnt, locked, ind, irig_data, en, cal, frame_done, sync_lost,
                 m_state, m_err, m_locked, m_ind, m_data, m_en, m_cal, m_fd, m_sl);
      end
      if (en === 1'b1) n_en++;
      if (cal === 1'b1) n_cal++;
      if (frame_done === 1'b1) n_fd++;
      if (sync_lost === 1'b1) n_sl++;
      @(negedge clk);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // High for hi cycles out of per; w = hi-1 because the counter clears on the rise cycle.
  task automatic pulse(int hi, int per);
    int unsigned a, s;
    a = cyc + 1;
    last_rise = a;
    irig_in = 1'b1;
    if (hi - 1 >= int'(TH_MAX)) evq.push_back('{a + TH_MAX + 4, K_ERR});
    repeat (hi) @(negedge clk);
    s = cyc + 1;
    irig_in = 1'b0;
    if (hi - 1 < int'(TH_MAX)) evq.push_back('{s + 3, classify(hi - 1)});
    repeat (per - hi) @(negedge clk);
  endtask

  task automatic hold_low(int extra);
    int unsigned nxt;
    nxt = cyc + 1 + extra;
    if (nxt - last_rise > TH_DEAD + 1) evq.push_back('{last_rise + TH_DEAD + 4, K_ERR});
    repeat (extra) @(negedge clk);
  endtask

  function automatic int width_for(int k);
    case (k)
      K_ZERO:  return $urandom_range(34, 12);
      K_ONE:   return $urandom_range(63, 37);
      default: return $urandom_range(94, 67);
    endcase
  endfunction

  task automatic send_expected(bit ones_only);
    int k;
    k = marker_slot((m_ind + 1) % 100) ? K_MARK : (ones_only ? K_ONE : int'($urandom_range(1, 0)));
    pulse(width_for(k), 100);
  endtask

  task automatic ce_pulse();
    int unsigned s;
    last_rise = cyc + 1;
    irig_in = 1'b1;
    repeat (30) @(negedge clk);
    ce = 1'b0;
    repeat (50) @(negedge clk);
    ce = 1'b1;
    repeat (20) @(negedge clk);
    s = cyc + 1;
    irig_in = 1'b0;
    evq.push_back('{s + 3, K_ONE});   // 50 enabled high cycles: still a one
    repeat (40) @(negedge clk);
  endtask

  task automatic do_reset();
    hrd_rst_n = 1'b0;
    @(negedge clk);
    check("rst_ind", ind, 0);
    check("rst_locked", locked, 0);
    check("rst_state", state, 0);
    hrd_rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, c0;
    int bounds[8] = '{10, 11, 35, 36, 65, 66, 95, 96};
    // 1: reset with a toggling line
    hrd_rst_n = 1'b0;
    repeat (3) begin irig_in = 1'($urandom); @(negedge clk); end
    irig_in = 1'b0;
    check("rst_en", en, 0);
    check("rst_data", irig_data, 0);
    check("rst_err", err_cnt, 0);
    check("rst_state0", state, 0);
    check("rst_cal", {cal, frame_done, sync_lost, locked}, 0);
    hrd_rst_n = 1'b1;

    // 2: acquire with M, M, 0
    pulse(80, 100);
    pulse(80, 100);
    check("acq_ind", ind, 0);
    check("acq_data", irig_data, 3'b111);
    check("acq_locked", locked, 1);
    check("acq_cal_count", n_cal, 1);
    pulse(20, 100);
    check("acq_zero_ind", ind, 1);
    check("acq_zero_data", irig_data, 3'b001);
    check("acq_en_count", n_en, 2);

    // 3: one full frame of markers and ones
    b0 = n_en; c0 = n_fd;
    repeat (100) send_expected(1'b1);
    check("frame_en_count", n_en - b0, 100);
    check("frame_done_count", n_fd - c0, 1);
    check("frame_locked", locked, 1);
    check("frame_ind", ind, 1);

    // 4: misplaced marker at ind 5, then relock
    while (m_ind != 4) send_expected(1'b0);
    b0 = n_en;
    pulse(80, 100);
    check("mis_en", n_en - b0, 0);
    check("mis_sync_lost", n_sl, 1);
    check("mis_locked", locked, 0);
    check("mis_err", err_cnt, 1);
    check("mis_ind", ind, 0);
    pulse(80, 100);
    check("relock_half", locked, 0);
    pulse(80, 100);
    check("relock", locked, 1);

    // 5: over-long pulse, glitch and dead-line boundary
    b0 = n_en;
    pulse(96, 115);
    pulse(5, 100);
    check("err_long_glitch", err_cnt, 3);
    check("err_no_en", n_en - b0, 0);
    pulse(20, 100); hold_low(21);
    pulse(20, 100); hold_low(22);
    pulse(20, 100);
    check("dead_err", err_cnt, 4);

    // 6: clock-enable stall mid-pulse, then reset mid-frame
    pulse(80, 100);
    pulse(80, 100);
    while (marker_slot((m_ind + 1) % 100)) send_expected(1'b0);
    b0 = n_en;
    ce_pulse();
    check("ce_data", irig_data, 3'b011);
    check("ce_en", n_en - b0, 1);
    while (m_ind != 42) send_expected(1'b0);
    do_reset();

    // 7: randomized traffic mixing well-formed frames with arbitrary widths
    for (int i = 0; i < 300; i++) begin
      int r, hi;
      r = $urandom_range(7, 0);
      if (r < 4) begin
        if (m_state == 2) send_expected(1'b0);
        else pulse(width_for(K_MARK), 100);
      end else begin
        hi = (r == 4) ? bounds[$urandom_range(7, 0)] : int'($urandom_range(100, 2));
        pulse(hi, hi + int'($urandom_range(20, 15)));
      end
    end
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
